// File: rtl/wb_arb_pkg.sv
// Shared constants for the two-master Wishbone RAM arbiter: grant encodings and CTI codes.
package wb_arb_pkg;

  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_M0   = 2'b01;
  localparam logic [1:0] GNT_M1   = 2'b10;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INC     = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

endpackage

// File: rtl/wb_arb_rr_pick.sv
// Combinational round-robin picker for two requesters; holds the current owner while it
// keeps its cycle open.
module wb_arb_rr_pick
  import wb_arb_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       last_i,
  input  logic       hold_i,
  input  logic [1:0] cur_gnt_i,
  output logic [1:0] next_gnt_o
);

  always_comb begin
    next_gnt_o = GNT_NONE;
    if (hold_i) begin
      next_gnt_o = cur_gnt_i;
    end else if (&req_i) begin
      // Tie: the master that was not granted most recently wins.
      next_gnt_o = last_i ? GNT_M0 : GNT_M1;
    end else if (req_i[0]) begin
      next_gnt_o = GNT_M0;
    end else if (req_i[1]) begin
      next_gnt_o = GNT_M1;
    end
  end

endmodule

// File: rtl/wb_mem_arbiter.sv
// Two-master round-robin Wishbone B3 arbiter in front of the main RAM port.
// Optional stall watchdog enabled by defining WB_MEM_ARBITER_TIMEOUT_EN.
module wb_mem_arbiter
  import wb_arb_pkg::*;
#(
  parameter int unsigned AW             = 32,
  parameter int unsigned DW             = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_ni,

  input  logic [AW-1:0]   m0_adr_i,
  input  logic [DW-1:0]   m0_dat_i,
  input  logic [DW/8-1:0] m0_sel_i,
  input  logic            m0_we_i,
  input  logic            m0_cyc_i,
  input  logic            m0_stb_i,
  input  logic [2:0]      m0_cti_i,
  input  logic [1:0]      m0_bte_i,
  output logic [DW-1:0]   m0_dat_o,
  output logic            m0_ack_o,
  output logic            m0_err_o,
  output logic            m0_rty_o,

  input  logic [AW-1:0]   m1_adr_i,
  input  logic [DW-1:0]   m1_dat_i,
  input  logic [DW/8-1:0] m1_sel_i,
  input  logic            m1_we_i,
  input  logic            m1_cyc_i,
  input  logic            m1_stb_i,
  input  logic [2:0]      m1_cti_i,
  input  logic [1:0]      m1_bte_i,
  output logic [DW-1:0]   m1_dat_o,
  output logic            m1_ack_o,
  output logic            m1_err_o,
  output logic            m1_rty_o,

  output logic [AW-1:0]   s_adr_o,
  output logic [DW-1:0]   s_dat_o,
  output logic [DW/8-1:0] s_sel_o,
  output logic            s_we_o,
  output logic            s_cyc_o,
  output logic            s_stb_o,
  output logic [2:0]      s_cti_o,
  output logic [1:0]      s_bte_o,
  input  logic [DW-1:0]   s_dat_i,
  input  logic            s_ack_i,
  input  logic            s_err_i,
  input  logic            s_rty_i,

  output logic [1:0]      grant_o
);

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 256) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be in 2..256");
  end

  logic [1:0] gnt_q, gnt_d;
  logic       last_q;
  logic [1:0] req;
  logic       hold;
  logic       stb_raw;
  logic       timeout;

  assign req  = {m1_cyc_i, m0_cyc_i};
  assign hold = |(gnt_q & req);

  wb_arb_rr_pick u_pick (
    .req_i      (req),
    .last_i     (last_q),
    .hold_i     (hold),
    .cur_gnt_i  (gnt_q),
    .next_gnt_o (gnt_d)
  );

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      gnt_q  <= GNT_NONE;
      last_q <= 1'b1;
    end else begin
      gnt_q <= gnt_d;
      if (gnt_d == GNT_M0) begin
        last_q <= 1'b0;
      end else if (gnt_d == GNT_M1) begin
        last_q <= 1'b1;
      end
    end
  end

  // Slave-side request is a pure mux of the registered grant, so the async reset of gnt_q
  // deasserts the slave port immediately.
  always_comb begin
    s_adr_o = '0;
    s_dat_o = '0;
    s_sel_o = '0;
    s_we_o  = 1'b0;
    s_cyc_o = 1'b0;
    stb_raw = 1'b0;
    s_cti_o = '0;
    s_bte_o = '0;
    unique case (gnt_q)
      GNT_M0: begin
        s_adr_o = m0_adr_i;
        s_dat_o = m0_dat_i;
        s_sel_o = m0_sel_i;
        s_we_o  = m0_we_i;
        s_cyc_o = m0_cyc_i;
        stb_raw = m0_stb_i;
        s_cti_o = m0_cti_i;
        s_bte_o = m0_bte_i;
      end
      GNT_M1: begin
        s_adr_o = m1_adr_i;
        s_dat_o = m1_dat_i;
        s_sel_o = m1_sel_i;
        s_we_o  = m1_we_i;
        s_cyc_o = m1_cyc_i;
        stb_raw = m1_stb_i;
        s_cti_o = m1_cti_i;
        s_bte_o = m1_bte_i;
      end
      default: ;
    endcase
  end

  assign s_stb_o = stb_raw & ~timeout;

`ifdef WB_MEM_ARBITER_TIMEOUT_EN
  localparam logic [7:0] CntLast = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] cnt_q;
  logic       resp;

  assign resp    = s_ack_i | s_err_i | s_rty_i;
  assign timeout = stb_raw && (cnt_q == CntLast);

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      cnt_q <= '0;
    end else if ((gnt_d != gnt_q) || resp || timeout) begin
      cnt_q <= '0;
    end else if (stb_raw) begin
      cnt_q <= cnt_q + 8'd1;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;
  assign m0_ack_o = s_ack_i & gnt_q[0];
  assign m1_ack_o = s_ack_i & gnt_q[1];
  assign m0_err_o = (s_err_i | timeout) & gnt_q[0];
  assign m1_err_o = (s_err_i | timeout) & gnt_q[1];
  assign m0_rty_o = s_rty_i & gnt_q[0];
  assign m1_rty_o = s_rty_i & gnt_q[1];
  assign grant_o  = gnt_q;

endmodule

// File: tb/tb_wb_mem_arbiter.sv
// Directed self-checking bench for wb_mem_arbiter; watchdog path is checked when
// WB_MEM_ARBITER_TIMEOUT_EN is defined (TIMEOUT_CYCLES=8).
module tb_wb_mem_arbiter;
  import wb_arb_pkg::*;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [AW-1:0]   m0_adr, m1_adr, s_adr;
  logic [DW-1:0]   m0_dat, m1_dat, m0_rdat, m1_rdat, s_wdat, s_rdat;
  logic [DW/8-1:0] m0_sel, m1_sel, s_sel;
  logic            m0_we, m1_we, m0_cyc, m1_cyc, m0_stb, m1_stb;
  logic [2:0]      m0_cti, m1_cti, s_cti;
  logic [1:0]      m0_bte, m1_bte, s_bte;
  logic            m0_ack, m1_ack, m0_err, m1_err, m0_rty, m1_rty;
  logic            s_we, s_cyc, s_stb, s_ack, s_err, s_rty;
  logic [1:0]      grant;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wb_mem_arbiter #(.AW(AW), .DW(DW), .TIMEOUT_CYCLES(8)) dut (
    .wb_clk_i (clk),      .wb_rst_ni (rst_n),
    .m0_adr_i (m0_adr),   .m0_dat_i (m0_dat),   .m0_sel_i (m0_sel),   .m0_we_i (m0_we),
    .m0_cyc_i (m0_cyc),   .m0_stb_i (m0_stb),   .m0_cti_i (m0_cti),   .m0_bte_i (m0_bte),
    .m0_dat_o (m0_rdat),  .m0_ack_o (m0_ack),   .m0_err_o (m0_err),   .m0_rty_o (m0_rty),
    .m1_adr_i (m1_adr),   .m1_dat_i (m1_dat),   .m1_sel_i (m1_sel),   .m1_we_i (m1_we),
    .m1_cyc_i (m1_cyc),   .m1_stb_i (m1_stb),   .m1_cti_i (m1_cti),   .m1_bte_i (m1_bte),
    .m1_dat_o (m1_rdat),  .m1_ack_o (m1_ack),   .m1_err_o (m1_err),   .m1_rty_o (m1_rty),
    .s_adr_o  (s_adr),    .s_dat_o  (s_wdat),   .s_sel_o  (s_sel),    .s_we_o  (s_we),
    .s_cyc_o  (s_cyc),    .s_stb_o  (s_stb),    .s_cti_o  (s_cti),    .s_bte_o (s_bte),
    .s_dat_i  (s_rdat),   .s_ack_i  (s_ack),    .s_err_i  (s_err),    .s_rty_i (s_rty),
    .grant_o  (grant)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    m0_adr = '0; m0_dat = '0; m0_sel = '0; m0_we = 0; m0_cyc = 0; m0_stb = 0;
    m0_cti = CTI_CLASSIC; m0_bte = '0;
    m1_adr = '0; m1_dat = '0; m1_sel = '0; m1_we = 0; m1_cyc = 0; m1_stb = 0;
    m1_cti = CTI_CLASSIC; m1_bte = '0;
    s_rdat = '0; s_ack = 0; s_err = 0; s_rty = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clear_inputs();
    m0_adr = 32'h1000_0000; m0_cyc = 1; m0_stb = 1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (s_cyc !== 1'b0) begin errors++; $display("FAIL rst_s_cyc got %b exp 0", s_cyc); end
    checks++;
    if (grant !== 2'b00) begin errors++; $display("FAIL rst_grant got %b exp 00", grant); end
    checks++;
    if (m0_ack !== 1'b0 || s_stb !== 1'b0) begin
      errors++; $display("FAIL rst_outs got ack=%b stb=%b exp 0 0", m0_ack, s_stb);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    checks++;
    if (grant !== GNT_M0) begin errors++; $display("FAIL rel_grant got %b exp 01", grant); end
    checks++;
    if (s_adr !== 32'h1000_0000 || s_cyc !== 1'b1) begin
      errors++; $display("FAIL rel_adr got %h cyc=%b exp 10000000 1", s_adr, s_cyc);
    end
    m0_cyc = 0; m0_stb = 0;
    tick();
    checks++;
    if (grant !== GNT_NONE) begin errors++; $display("FAIL rel_idle got %b exp 00", grant); end
  endtask

  task automatic test_tie();
    do_reset();
    m0_adr = 32'h0000_00A0; m0_cyc = 1; m0_stb = 1;
    m1_adr = 32'h0000_00A1; m1_cyc = 1; m1_stb = 1;
    tick();
    checks++;
    if (grant !== GNT_M0 || s_adr !== 32'h0000_00A0) begin
      errors++; $display("FAIL tie_first got %b adr=%h exp 01 a0", grant, s_adr);
    end
    // Owner drops cyc in the same cycle as its ack; the ack must still reach it.
    s_ack = 1; s_rdat = 32'h1234_5678; m0_cyc = 0; m0_stb = 0;
    #1;
    checks++;
    if (m0_ack !== 1'b1 || m1_ack !== 1'b0 || m0_rdat !== 32'h1234_5678) begin
      errors++; $display("FAIL tie_ack got m0=%b m1=%b dat=%h exp 1 0 12345678",
                         m0_ack, m1_ack, m0_rdat);
    end
    tick();
    s_ack = 0;
    checks++;
    if (grant !== GNT_M1 || s_adr !== 32'h0000_00A1) begin
      errors++; $display("FAIL tie_handover got %b adr=%h exp 10 a1", grant, s_adr);
    end
    m1_cyc = 0; m1_stb = 0;
    tick();
    checks++;
    if (grant !== GNT_NONE) begin errors++; $display("FAIL tie_idle got %b exp 00", grant); end
    m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1;
    tick();
    checks++;
    if (grant !== GNT_M0) begin errors++; $display("FAIL tie_second got %b exp 01", grant); end
    m1_cyc = 0; m1_stb = 0;
    m0_cyc = 0; m0_stb = 0;
    tick();
  endtask

  task automatic test_burst();
    logic [2:0] exp_cti;
    // last = m0 now, so the tie goes to m1.
    m0_cyc = 1; m0_stb = 1; m0_adr = 32'h0000_0B00;
    m1_cyc = 1; m1_stb = 1; m1_adr = 32'h0000_2000; m1_bte = 2'b00;
    tick();
    checks++;
    if (grant !== GNT_M1) begin errors++; $display("FAIL burst_grant got %b exp 10", grant); end
    for (int i = 0; i < 4; i++) begin
      exp_cti = (i < 3) ? CTI_INC : CTI_EOB;
      m1_cti = exp_cti;
      m1_adr = 32'h0000_2000 + 32'(4 * i);
      s_ack = 1;
      if (i == 3) begin m1_cyc = 0; m1_stb = 0; end
      #1;
      checks++;
      if (m1_ack !== 1'b1 || m0_ack !== 1'b0 || s_cti !== exp_cti ||
          s_adr !== 32'h0000_2000 + 32'(4 * i)) begin
        errors++; $display("FAIL burst_beat%0d got ack1=%b ack0=%b cti=%b adr=%h", i,
                           m1_ack, m0_ack, s_cti, s_adr);
      end
      tick();
      if (i < 3) begin
        checks++;
        if (grant !== GNT_M1) begin
          errors++; $display("FAIL burst_hold%0d got %b exp 10", i, grant);
        end
      end
    end
    s_ack = 0;
    m1_cti = CTI_CLASSIC;
    checks++;
    if (grant !== GNT_M0 || s_adr !== 32'h0000_0B00) begin
      errors++; $display("FAIL burst_after got %b adr=%h exp 01 b00", grant, s_adr);
    end
  endtask

  task automatic test_err();
    // m0 still owns the bus from the burst test.
    m0_we = 1; m0_sel = 4'b0101; m0_dat = 32'hDEAD_BEEF;
    m1_cyc = 1; m1_stb = 1; m1_we = 0; m1_sel = 4'b1010; m1_dat = 32'h5555_AAAA;
    s_err = 1;
    #1;
    checks++;
    if (m0_err !== 1'b1 || m1_err !== 1'b0) begin
      errors++; $display("FAIL err_route got m0=%b m1=%b exp 1 0", m0_err, m1_err);
    end
    checks++;
    if (s_sel !== 4'b0101 || s_wdat !== 32'hDEAD_BEEF || s_we !== 1'b1) begin
      errors++; $display("FAIL err_mux got sel=%b dat=%h we=%b exp 0101 deadbeef 1",
                         s_sel, s_wdat, s_we);
    end
    s_rty = 1; s_err = 0;
    #1;
    checks++;
    if (m0_rty !== 1'b1 || m1_rty !== 1'b0) begin
      errors++; $display("FAIL rty_route got m0=%b m1=%b exp 1 0", m0_rty, m1_rty);
    end
    s_rty = 0;
    m0_cyc = 0; m0_stb = 0; m0_we = 0;
    tick();
    checks++;
    if (grant !== GNT_M1 || s_sel !== 4'b1010) begin
      errors++; $display("FAIL err_handover got %b sel=%b exp 10 1010", grant, s_sel);
    end
    m1_cyc = 0; m1_stb = 0;
    tick();
    s_ack = 1; s_err = 1;
    #1;
    checks++;
    if ({m1_ack, m0_ack, m1_err, m0_err} !== 4'b0000 || s_cyc !== 1'b0 || s_adr !== '0) begin
      errors++; $display("FAIL idle_resp got acks=%b%b errs=%b%b cyc=%b exp all 0",
                         m1_ack, m0_ack, m1_err, m0_err, s_cyc);
    end
    s_ack = 0; s_err = 0;
  endtask

  task automatic test_reset_mid_burst();
    m1_cyc = 1; m1_stb = 1; m1_cti = CTI_INC; m1_adr = 32'h0000_3000;
    tick();
    checks++;
    if (grant !== GNT_M1) begin errors++; $display("FAIL mid_grant got %b exp 10", grant); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (s_cyc !== 1'b0 || s_stb !== 1'b0 || grant !== GNT_NONE) begin
      errors++; $display("FAIL mid_async got cyc=%b stb=%b gnt=%b exp 0 0 00",
                         s_cyc, s_stb, grant);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    checks++;
    if (grant !== GNT_M1 || s_adr !== 32'h0000_3000) begin
      errors++; $display("FAIL mid_regrant got %b adr=%h exp 10 3000", grant, s_adr);
    end
    m1_cyc = 0; m1_stb = 0; m1_cti = CTI_CLASSIC;
    tick();
  endtask

  task automatic test_timeout();
    m0_cyc = 1; m0_stb = 1; m0_adr = 32'h0000_4000;
    tick();
    checks++;
    if (grant !== GNT_M0) begin errors++; $display("FAIL to_grant got %b exp 01", grant); end
`ifdef WB_MEM_ARBITER_TIMEOUT_EN
    for (int k = 1; k <= 9; k++) begin
      checks++;
      if (k == 8) begin
        if (m0_err !== 1'b1 || s_stb !== 1'b0 || m1_err !== 1'b0) begin
          errors++; $display("FAIL to_pulse got err=%b stb=%b exp 1 0", m0_err, s_stb);
        end
      end else if (m0_err !== 1'b0 || s_stb !== 1'b1) begin
        errors++; $display("FAIL to_stall%0d got err=%b stb=%b exp 0 1", k, m0_err, s_stb);
      end
      tick();
    end
`else
    begin
      int err_seen = 0;
      int stb_drop = 0;
      for (int k = 0; k < 100; k++) begin
        if (m0_err !== 1'b0) err_seen++;
        if (s_stb !== 1'b1) stb_drop++;
        tick();
      end
      checks++;
      if (err_seen != 0 || stb_drop != 0) begin
        errors++; $display("FAIL to_none got errs=%0d stb_drops=%0d exp 0 0",
                           err_seen, stb_drop);
      end
    end
`endif
    m0_cyc = 0; m0_stb = 0;
    tick();
  endtask

  initial begin
    test_reset();
    test_tie();
    test_burst();
    test_err();
    test_reset_mid_burst();
    test_timeout();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
